gate_scan_ctrl: RTL and testbench

GATE_SCAN_CTRL -- requirements
Module: gate_scan_ctrl

---
 rtl/gate_scan_ctrl_pkg.sv | 40 ++++
 rtl/gate_scan_ctrl_if.sv | 22 ++
 rtl/gate_row_check.sv | 19 +
 rtl/gate_scan_ctrl.sv | 85 ++++++++
 tb/tb_gate_scan_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/gate_scan_ctrl_pkg.sv
// rtl/gate_scan_ctrl_pkg.sv - shared encodings and tables for the gate scan controller
package gate_scan_ctrl_pkg;

   typedef logic [1:0] state_t;
   typedef logic [1:0] row_t;
   typedef logic [6:0] func_vec_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_SETTLE = 2'd1;
   localparam state_t ST_SAMPLE = 2'd2;
   localparam state_t ST_DONE   = 2'd3;

   localparam int N_FUNC = 7;
   localparam int F_NOT  = 0;
   localparam int F_AND  = 1;
   localparam int F_NAND = 2;
   localparam int F_OR   = 3;
   localparam int F_NOR  = 4;
   localparam int F_XOR  = 5;
   localparam int F_XNOR = 6;

   // Expected primitive output of function f at row r lives at bit 4*f+r.
   localparam logic [27:0] EXP_TT = 28'h961E785;

   localparam int GATE_WIDTH = 14;

   // gate_out packs each function as a (_0, _1) pair, NOT in the top pair.
   function automatic int pos0(input int f);
      return 13 - 2 * f;
   endfunction

   function automatic int pos1(input int f);
      return 12 - 2 * f;
   endfunction

   function automatic logic exp_bit(input int f, input row_t r);
      return EXP_TT[4 * f + int'(r)];
   endfunction

endpackage

// File: rtl/gate_scan_ctrl_if.sv
// rtl/gate_scan_ctrl_if.sv - scan request, gate drive/observe and result bundle
interface gate_scan_ctrl_if;
   logic        start;
   logic        I1;
   logic        I0;
   logic [13:0] gate_out;
   logic        busy;
   logic        done;
   logic [27:0] tt;
   logic [6:0]  err;
   logic        pass;

   modport master (
      output start, gate_out,
      input  I1, I0, busy, done, tt, err, pass
   );

   modport slave (
      input  start, gate_out,
      output I1, I0, busy, done, tt, err, pass
   );
endinterface

// File: rtl/gate_row_check.sv
// rtl/gate_row_check.sv - per-row compare of gate outputs against the expected table
module gate_row_check
   import gate_scan_ctrl_pkg::*;
(
   input  row_t        r,
   input  logic [13:0] gate_out,
   output func_vec_t   row_err
);

   // A function fails a row when its two copies disagree or the primitive is wrong.
   always_comb begin
      row_err = '0;
      for (int f = 0; f < N_FUNC; f++) begin
         row_err[f] = (gate_out[pos0(f)] != gate_out[pos1(f)]) |
                      (gate_out[pos0(f)] != exp_bit(f, r));
      end
   end

endmodule

// File: rtl/gate_scan_ctrl.sv
// rtl/gate_scan_ctrl.sv - scans four input rows through a gate unit and grades it
module gate_scan_ctrl
   import gate_scan_ctrl_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input logic             clk,
   input logic             rst_n,
   gate_scan_ctrl_if.slave bus
);

   state_t      state;
   row_t        row;
   logic [3:0]  cnt;
   logic [27:0] tt_q;
   func_vec_t   err_q;
   logic        pass_q;
   func_vec_t   row_err;

   gate_row_check u_row_check (
      .r        (row),
      .gate_out (bus.gate_out),
      .row_err  (row_err)
   );

   // Scan sequencer: settle each row, capture it, then report once after row 3.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         row    <= '0;
         cnt    <= '0;
         tt_q   <= '0;
         err_q  <= '0;
         pass_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  row    <= '0;
                  cnt    <= '0;
                  tt_q   <= '0;
                  err_q  <= '0;
                  pass_q <= 1'b0;
                  state  <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (cnt == 4'(SETTLE - 1)) begin
                  state <= ST_SAMPLE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            ST_SAMPLE: begin
               for (int f = 0; f < N_FUNC; f++) begin
                  tt_q[4 * f + int'(row)] <= bus.gate_out[pos0(f)];
               end
               err_q <= err_q | row_err;
               if (row != 2'd3) begin
                  row   <= row + 2'd1;
                  cnt   <= '0;
                  state <= ST_SETTLE;
               end else begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               pass_q <= (err_q == '0);
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // The row register drives the gate inputs directly, so they rest at 11 after a scan.
   assign bus.I1   = row[1];
   assign bus.I0   = row[0];
   assign bus.busy = (state != ST_IDLE);
   assign bus.done = (state == ST_DONE);
   assign bus.tt   = tt_q;
   assign bus.err  = err_q;
   assign bus.pass = pass_q;

endmodule

// File: tb/tb_gate_scan_ctrl.sv
// tb/tb_gate_scan_ctrl.sv - randomized bench with a scan-level reference model
module tb_gate_scan_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;

   always #5 clk = ~clk;

   gate_scan_ctrl_if ifa();
   gate_scan_ctrl_if ifb();

   gate_scan_ctrl #(.SETTLE(1)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
   gate_scan_ctrl #(.SETTLE(3)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

   logic [13:0] go [2];
   logic        busy_o [2];
   logic        done_o [2];
   logic [1:0]  io_o [2];
   logic [27:0] tt_o [2];
   logic [6:0]  err_o [2];
   logic        pass_o [2];

   assign ifa.start = start;
   assign ifb.start = start;
   assign ifa.gate_out = go[0];
   assign ifb.gate_out = go[1];
   assign busy_o[0] = ifa.busy;   assign busy_o[1] = ifb.busy;
   assign done_o[0] = ifa.done;   assign done_o[1] = ifb.done;
   assign io_o[0] = {ifa.I1, ifa.I0};
   assign io_o[1] = {ifb.I1, ifb.I0};
   assign tt_o[0] = ifa.tt;       assign tt_o[1] = ifb.tt;
   assign err_o[0] = ifa.err;     assign err_o[1] = ifb.err;
   assign pass_o[0] = ifa.pass;   assign pass_o[1] = ifb.pass;

   // reference model state, one slot per DUT
   int          S [2] = '{1, 3};
   bit          act [2];
   int          k [2];
   int          row [2];
   logic [27:0] m_tt [2];
   logic [6:0]  m_err [2];
   bit          m_pass [2];
   logic [13:0] flip [2];
   logic [13:0] stuck [2];
   int          edge_n = 0;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s got=%0h exp=%0h edge=%0d", tag, got, exp, edge_n);
      else
         n_pass++;
   endtask

   // truth of each logic function; a = I1, b = I0, NOT acts on I0
   function automatic bit truth(input int f, input bit a, input bit b);
      case (f)
         0: return !b;
         1: return a & b;
         2: return !(a & b);
         3: return a | b;
         4: return !(a | b);
         5: return a ^ b;
         default: return !(a ^ b);
      endcase
   endfunction

   // gate unit response to row r with inversion and stuck-at-0 faults
   function automatic logic [13:0] gate_vec(input int r, input logic [13:0] fl, input logic [13:0] st);
      logic [13:0] v;
      bit a, b;
      a = r[1];
      b = r[0];
      for (int f = 0; f < 7; f++) begin
         v[13 - 2 * f] = truth(f, a, b);
         v[12 - 2 * f] = truth(f, a, b);
      end
      return (v ^ fl) & ~st;
   endfunction

   // valid gate data only in the cycle before each expected capture edge
   task automatic drive_go();
      for (int d = 0; d < 2; d++) begin
         int e;
         int p;
         e = edge_n + 1 - k[d];
         p = S[d] + 1;
         if (act[d] && (e % p == 0) && (e / p >= 1) && (e / p <= 4))
            go[d] = gate_vec(e / p - 1, flip[d], stuck[d]);
         else
            go[d] = 14'($urandom);
      end
   endtask

   task automatic model_edge(input int d);
      int e;
      int p;
      int r;
      logic [13:0] v;
      p = S[d] + 1;
      if (!rst_n) begin
         act[d] = 0; row[d] = 0; m_tt[d] = '0; m_err[d] = '0; m_pass[d] = 0;
      end else if (act[d]) begin
         e = edge_n - k[d];
         if ((e % p == 0) && (e / p >= 1) && (e / p <= 4)) begin
            r = e / p - 1;
            v = gate_vec(r, flip[d], stuck[d]);
            for (int f = 0; f < 7; f++) begin
               m_tt[d][4 * f + r] = v[13 - 2 * f];
               if ((v[13 - 2 * f] != v[12 - 2 * f]) || (v[13 - 2 * f] != truth(f, r[1], r[0])))
                  m_err[d][f] = 1'b1;
            end
            if (r < 3) row[d] = r + 1;
         end
         if (e == 4 * p + 1) begin
            act[d] = 0;
            m_pass[d] = (m_err[d] == '0);
         end
      end else if (start) begin
         act[d] = 1; k[d] = edge_n; row[d] = 0; m_tt[d] = '0; m_err[d] = '0; m_pass[d] = 0;
      end
   endtask

   task automatic compare(input int d);
      string n;
      bit exp_done;
      n = (d == 0) ? "a" : "b";
      exp_done = act[d] && ((edge_n - k[d]) == 4 * (S[d] + 1));
      chk({n, "_busy"}, 32'(busy_o[d]), 32'(act[d]));
      chk({n, "_done"}, 32'(done_o[d]), 32'(exp_done));
      chk({n, "_i1i0"}, 32'(io_o[d]), 32'(row[d][1:0]));
      chk({n, "_tt"}, 32'(tt_o[d]), 32'(m_tt[d]));
      chk({n, "_err"}, 32'(err_o[d]), 32'(m_err[d]));
      chk({n, "_pass"}, 32'(pass_o[d]), 32'(m_pass[d]));
   endtask

   task automatic step();
      drive_go();
      @(posedge clk);
      edge_n++;
      model_edge(0);
      model_edge(1);
      #1;
      compare(0);
      compare(1);
   endtask

   task automatic run_scan();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (19) step();
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         flip[d] = '0; stuck[d] = '0; act[d] = 0; k[d] = 0; row[d] = 0;
         m_tt[d] = '0; m_err[d] = '0; m_pass[d] = 0; go[d] = '0;
      end

      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();

      // clean scan with a stray start at edge k+3
      start = 1'b1; step();
      start = 1'b0; step(); step();
      start = 1'b1; step();
      start = 1'b0; repeat (16) step();
      chk("clean_tt", 32'(tt_o[0]), 32'h961E785);
      chk("clean_err", 32'(err_o[0]), 32'h0);
      chk("clean_pass", 32'(pass_o[0]), 32'h1);
      chk("clean_tt_s3", 32'(tt_o[1]), 32'h961E785);
      chk("clean_pass_s3", 32'(pass_o[1]), 32'h1);

      // Nand_1 stuck at 0
      stuck[0] = 14'h0100;
      run_scan();
      chk("nand1_err", 32'(err_o[0]), 32'b0000100);
      chk("nand1_pass", 32'(pass_o[0]), 32'h0);
      chk("nand1_tt", 32'(tt_o[0]), 32'h961E785);
      stuck[0] = '0;

      // both XOR copies inverted
      flip[0] = 14'h000C;
      run_scan();
      chk("xor_err", 32'(err_o[0]), 32'b0100000);
      chk("xor_tt_nib", 32'(tt_o[0][23:20]), 32'b1001);
      flip[0] = '0;

      // reset during row 2
      start = 1'b1; step();
      start = 1'b0; repeat (5) step();
      rst_n = 1'b0; step();
      rst_n = 1'b1;
      chk("midrst_busy", 32'(busy_o[0]), 32'h0);
      chk("midrst_i1i0", 32'(io_o[0]), 32'h0);
      chk("midrst_tt", 32'(tt_o[0]), 32'h0);
      repeat (20) step();

      // start held high across several scans
      start = 1'b1;
      repeat (30) step();
      start = 1'b0;
      repeat (20) step();

      // random starts, resets and faults
      for (int i = 0; i < 1500; i++) begin
         if (i % 50 == 0) begin
            for (int d = 0; d < 2; d++) begin
               case ($urandom_range(0, 3))
                  0: begin flip[d] = '0; stuck[d] = '0; end
                  1: begin flip[d] = 14'(1) << $urandom_range(0, 13); stuck[d] = '0; end
                  2: begin flip[d] = '0; stuck[d] = 14'(1) << $urandom_range(0, 13); end
                  default: begin flip[d] = 14'($urandom) & 14'($urandom); stuck[d] = '0; end
               endcase
            end
         end
         start = ($urandom_range(0, 5) == 0);
         rst_n = ($urandom_range(0, 79) != 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
